mem_rr_arbiter: RTL

//  Shares one single-port synchronous SRAM (generic_memory: 1-cycle read latency) between
//  NUM_PORTS requesters (e.g. AXI-to-mem read path, write path, atomics RMW unit).

---
 rtl/mem_rr_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_rr_arbiter.sv
// Purpose : round-robin arbiter sharing one single-port sync SRAM between NUM_PORTS requesters.
// Latency : grant is combinational in the request cycle; rvalid_o/rdata_o follow one cycle later.
// Backpr. : a requester not granted holds its request fields stable; no response-side stall exists.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_i/we_i/lock_i            per-port request, write enable, hold-grant request
//   addr_i/be_i/wdata_i          per-port packed word address, byte enables, write data
//   gnt_o                        one-hot grant (0 while rst_i)
//   rvalid_o/rdata_o             one-hot response valid (read data or write ack), broadcast read data
//   mem_req_o..mem_wdata_o       muxed access toward the SRAM macro; mem_rdata_i returns from it
//
// Build option: define MEM_ARB_LOCK_EN to let a granted port with lock_i set keep exclusive
// access until it drops lock_i. Without it lock_i is accepted but ignored.
module mem_rr_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 64
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_PORTS-1:0]              req_i,
    input  logic [NUM_PORTS-1:0]              we_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
    input  logic [NUM_PORTS-1:0]              lock_i,
    output logic [NUM_PORTS-1:0]              gnt_o,
    output logic [NUM_PORTS-1:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]             rdata_o,
    output logic                              mem_req_o,
    output logic                              mem_we_o,
    output logic [ADDR_WIDTH-1:0]             mem_addr_o,
    output logic [DATA_WIDTH/8-1:0]           mem_be_o,
    output logic [DATA_WIDTH-1:0]             mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]             mem_rdata_i
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int PTR_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [PTR_WIDTH-1:0] LAST_IDX = PTR_WIDTH'(NUM_PORTS - 1);

    logic [PTR_WIDTH-1:0] rr_ptr;
    logic [PTR_WIDTH-1:0] gnt_idx;
    logic                 gnt_found;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] resp;

`ifdef MEM_ARB_LOCK_EN
    logic [PTR_WIDTH-1:0] lock_owner;
    logic                 lock_vld;
    logic                 lock_hold;

    // The owner keeps exclusivity only while it still asserts lock_i; the cycle it drops
    // lock_i already arbitrates normally.
    assign lock_hold = lock_vld && lock_i[lock_owner];

    always_comb begin
        eligible = req_i;
        if (lock_hold) begin
            eligible             = '0;
            eligible[lock_owner] = req_i[lock_owner];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_vld   <= 1'b0;
            lock_owner <= '0;
        end else if (gnt_found && lock_i[gnt_idx]) begin
            lock_vld   <= 1'b1;
            lock_owner <= gnt_idx;
        end else if (lock_vld && !lock_i[lock_owner]) begin
            lock_vld   <= 1'b0;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^lock_i;
    assign eligible    = req_i;
`endif

    // First eligible port at or above rr_ptr, wrapping back to port 0.
    always_comb begin
        int cand;
        cand      = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            if (!gnt_found && eligible[PTR_WIDTH'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_WIDTH'(cand);
            end
        end
        if (rst_i) begin
            gnt_found = 1'b0;
        end
    end

    // Grant decode and field mux; everything is zero when nothing is granted.
    always_comb begin
        gnt_o       = '0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (gnt_found && (gnt_idx == PTR_WIDTH'(k))) begin
                gnt_o[k]    = 1'b1;
                mem_we_o    = we_i[k];
                mem_addr_o  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                mem_be_o    = be_i[k*BE_WIDTH +: BE_WIDTH];
                mem_wdata_o = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign mem_req_o = gnt_found;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
            resp   <= '0;
        end else begin
            resp <= gnt_o;
            if (gnt_found) begin
                rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // A response registered just before reset is suppressed rather than delivered.
    assign rvalid_o = resp & ~{NUM_PORTS{rst_i}};
    assign rdata_o  = mem_rdata_i;

endmodule
